// File: rtl/seq_pkg.sv
// Shared constants and types for the instruction sequencer.
package seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALU_W = 6;

  // Supported major opcodes
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // funct7 / imm[11:5] patterns
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 values with special decode handling
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // ALU_Control codes: {2'b00, alt, funct3}
  localparam logic [ALU_W-1:0] ALU_ADD  = 6'b000000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 6'b001000;
  localparam logic [ALU_W-1:0] ALU_SLL  = 6'b000001;
  localparam logic [ALU_W-1:0] ALU_SLT  = 6'b000010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 6'b000011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 6'b000100;
  localparam logic [ALU_W-1:0] ALU_SRL  = 6'b000101;
  localparam logic [ALU_W-1:0] ALU_SRA  = 6'b001101;
  localparam logic [ALU_W-1:0] ALU_OR   = 6'b000110;
  localparam logic [ALU_W-1:0] ALU_AND  = 6'b000111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-deep instruction queue; a push is accepted while full if a pop happens in the same cycle.
module instr_fifo
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] din,
  input  logic            pop,
  output logic [XLEN-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_sequencer.sv
// IDLE->DECODE->EXEC controller for the regfile+ALU datapath.
// Optional retired-instruction counter enabled by SEQ_RETIRE_CNT_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  instr_in,
  output logic             instr_ready,
  output logic [XLEN-1:0]  instruction,
  output logic [ALU_W-1:0] ALU_Control,
  output logic             op_B_sel,
  output logic             wEn,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  state_t           state;
  logic [XLEN-1:0]  ir;
  logic [XLEN-1:0]  head;
  logic             run;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [6:0]       opc;
  logic [6:0]       f7;
  logic [2:0]       f3;
  logic [4:0]       rd;
  logic             alt;
  logic             dec_legal;
  logic             dec_bsel;
  logic [ALU_W-1:0] dec_alu;

  assign instr_ready = run && !full;
  assign push        = instr_valid && instr_ready;
  assign pop         = (state == IDLE) && !empty;
  assign busy        = (state != IDLE) || !empty;
  assign instruction = ir;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (instr_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Decode the held instruction into ALU controls and a legality flag
  always_comb begin
    alt       = 1'b0;
    dec_legal = 1'b0;
    dec_bsel  = 1'b0;
    dec_alu   = ALU_ADD;
    case (opc)
      OP_R: begin
        alt       = f7[5];
        dec_legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        dec_alu   = {2'b00, alt, f3};
      end
      OP_I: begin
        dec_bsel = 1'b1;
        case (f3)
          F3_SLL: dec_legal = (f7 == F7_BASE);
          F3_SR: begin
            alt       = f7[5];
            dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: dec_legal = 1'b1;
        endcase
        dec_alu = {2'b00, alt, f3};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Sequencer FSM with registered datapath controls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      run         <= 1'b0;
      ir          <= '0;
      ALU_Control <= '0;
      op_B_sel    <= 1'b0;
      wEn         <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          wEn     <= 1'b0;
          illegal <= 1'b0;
          if (pop) begin
            ir    <= head;
            state <= DECODE;
          end
        end
        DECODE: begin
          ALU_Control <= dec_alu;
          op_B_sel    <= dec_bsel;
          wEn         <= dec_legal && (rd != 5'd0);
          illegal     <= !dec_legal;
          state       <= EXEC;
        end
        EXEC: begin
          wEn     <= 1'b0;
          illegal <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Count legal instructions as they leave EXEC; x0 destinations still retire
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if ((state == EXEC) && !illegal) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign retired_count = cnt;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: transaction-level reference model plus
// a behavioural regfile/ALU standing in for the datapath.
module tb_instr_sequencer;

  localparam int unsigned DEPTH = 2;
  localparam logic [6:0]  OPR   = 7'b0110011;
  localparam logic [6:0]  OPI   = 7'b0010011;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [5:0]  ALU_Control;
  logic        op_B_sel;
  logic        wEn;
  logic        busy;
  logic        illegal;
  logic [15:0] retired_count;

  instr_sequencer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_in      (instr_in),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .ALU_Control   (ALU_Control),
    .op_B_sel      (op_B_sel),
    .wEn           (wEn),
    .busy          (busy),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc    = 0;

  // reference model state
  logic [31:0] mq[$];
  int          ph;
  logic [31:0] m_ir;
  logic        m_run;
  logic [15:0] m_cnt;
  logic [31:0] exp_rf [32];
  logic [31:0] tb_rf  [32];

  // DUT outputs sampled 1 time unit after each rising edge
  logic        s_ready, s_wen, s_bsel, s_busy, s_ill;
  logic [31:0] s_instr;
  logic [5:0]  s_alu;
  logic [15:0] s_ret;

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPI};
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction

  function automatic logic ref_legal(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    if (w[6:0] == OPR) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (w[6:0] == OPI) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // expected ALU code for a legal instruction: sub and sra/srai set the alt bit
  function automatic logic [5:0] ref_alu(input logic [31:0] w);
    logic is_alt;
    is_alt = w[30] && ((w[6:0] == OPR) || (w[14:12] == 3'd5));
    return {2'b00, is_alt, w[14:12]};
  endfunction

  // architectural result of an instruction from its mnemonic semantics
  function automatic logic [31:0] sem(input logic [31:0] w, input logic [31:0] a, input logic [31:0] r2);
    logic [31:0] b;
    logic        alt;
    logic [2:0]  f3;
    f3  = w[14:12];
    alt = w[30];
    if (w[6:0] == OPI) begin
      b = {{20{w[31]}}, w[31:20]};
      if (f3 != 3'd5) alt = 1'b0;
    end else begin
      b = r2;
    end
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // stand-in datapath ALU driven by ALU_Control
  function automatic logic [31:0] alu_top(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    case (code)
      6'b000000: return a + b;
      6'b001000: return a - b;
      6'b000001: return a << b[4:0];
      6'b000010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b000011: return (a < b) ? 32'd1 : 32'd0;
      6'b000100: return a ^ b;
      6'b000101: return a >> b[4:0];
      6'b001101: return 32'($signed(a) >>> b[4:0]);
      6'b000110: return a | b;
      6'b000111: return a & b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int         kind;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    kind = $urandom_range(0, 9);
    f3   = 3'($urandom);
    rd   = 5'($urandom);
    rs1  = 5'($urandom);
    rs2  = 5'($urandom);
    imm  = 12'($urandom);
    case (kind)
      0, 1, 2: return mk_r(7'h00, rs2, rs1, f3, rd);
      3:       return mk_r(7'h20, rs2, rs1, ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd0, rd);
      4, 5: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return mk_i(imm, rs1, f3, rd);
      end
      6:       return mk_i({7'h10, imm[4:0]}, rs1, ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5, rd);
      7:       return mk_r(7'h20, rs2, rs1, 3'd4, rd);
      8:       return mk_r(7'h01, rs2, rs1, f3, rd);
      default: return {imm, rs1, f3, rd, 7'b0110111};
    endcase
  endfunction

  function automatic logic exp_wen();
    return (ph == 2) && ref_legal(m_ir) && (m_ir[11:7] != 5'd0);
  endfunction

  function automatic logic exp_ill();
    return (ph == 2) && !ref_legal(m_ir);
  endfunction

  function automatic logic exp_busy();
    return (ph != 0) || (mq.size() != 0);
  endfunction

  function automatic logic exp_ready();
    return m_run && (mq.size() < DEPTH);
  endfunction

  function automatic logic [15:0] exp_ret();
`ifdef SEQ_RETIRE_CNT_EN
    return m_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic sample();
    s_ready = instr_ready;
    s_instr = instruction;
    s_alu   = ALU_Control;
    s_bsel  = op_B_sel;
    s_wen   = wEn;
    s_busy  = busy;
    s_ill   = illegal;
    s_ret   = retired_count;
  endtask

  task automatic model_reset();
    mq.delete();
    ph    = 0;
    m_ir  = '0;
    m_run = 1'b0;
    m_cnt = '0;
  endtask

  // one clock: advance datapath stand-in and reference model, then sample
  task automatic step();
    logic acc;
    logic [31:0] b;
    @(posedge clock);
    cyc++;
    if (s_wen && s_instr[11:7] != 5'd0) begin
      b = s_bsel ? {{20{s_instr[31]}}, s_instr[31:20]} : tb_rf[s_instr[24:20]];
      tb_rf[s_instr[11:7]] = alu_top(s_alu, tb_rf[s_instr[19:15]], b);
    end
    acc = instr_valid && exp_ready();
    case (ph)
      0: if (mq.size() != 0) begin m_ir = mq.pop_front(); ph = 1; end
      1: ph = 2;
      default: begin
        if (ref_legal(m_ir)) begin
          if (m_ir[11:7] != 5'd0)
            exp_rf[m_ir[11:7]] = sem(m_ir, exp_rf[m_ir[19:15]], exp_rf[m_ir[24:20]]);
          m_cnt = m_cnt + 16'd1;
        end
        ph = 0;
      end
    endcase
    if (acc) mq.push_back(instr_in);
    m_run = 1'b1;
    #1;
    sample();
  endtask

  task automatic drain();
    instr_valid = 1'b0;
    for (int i = 0; i < 40 && exp_busy(); i++) step();
    step();
    checks++;
    if (s_busy !== 1'b0) $display("FAIL drain_busy: busy=%b required 0", s_busy);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr_valid = 1'b0;
    instr_in = '0;
    model_reset();
    for (int i = 0; i < 32; i++) begin exp_rf[i] = '0; tb_rf[i] = '0; end
    repeat (2) @(posedge clock);
    #1;
    sample();
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", s_ready); else passes++;
    checks++; if (s_instr !== 32'd0) $display("FAIL reset_instr: got %h required 0", s_instr); else passes++;
    checks++; if (s_alu !== 6'd0 || s_bsel !== 1'b0) $display("FAIL reset_ctrl: alu=%b bsel=%b required 0", s_alu, s_bsel); else passes++;
    checks++; if (s_wen !== 1'b0 || s_ill !== 1'b0 || s_busy !== 1'b0) $display("FAIL reset_flags: wEn=%b ill=%b busy=%b required 0", s_wen, s_ill, s_busy); else passes++;
    checks++; if (s_ret !== 16'd0) $display("FAIL reset_count: got %0d required 0", s_ret); else passes++;
    @(negedge clock);
    reset = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", s_ready); else passes++;
  endtask

  task automatic test_addi();
    logic [15:0] c0;
    c0 = exp_ret();
    instr_valid = 1'b1;
    instr_in = 32'h00100593;
    step();
    instr_valid = 1'b0;
    step();
    checks++; if (s_wen !== 1'b0) $display("FAIL addi_decode_wen: got %b required 0", s_wen); else passes++;
    step();
    checks++; if (s_wen !== 1'b1) $display("FAIL addi_exec_wen: got %b required 1", s_wen); else passes++;
    checks++; if (s_alu !== 6'b000000 || s_bsel !== 1'b1) $display("FAIL addi_ctrl: alu=%b bsel=%b required 000000/1", s_alu, s_bsel); else passes++;
    checks++; if (s_instr !== 32'h00100593) $display("FAIL addi_instr: got %h required 00100593", s_instr); else passes++;
    step();
    checks++; if (tb_rf[11] !== 32'd1) $display("FAIL addi_x11: got %h required 1", tb_rf[11]); else passes++;
`ifdef SEQ_RETIRE_CNT_EN
    checks++; if (s_ret !== c0 + 16'd1) $display("FAIL addi_retired: got %0d required %0d", s_ret, c0 + 16'd1); else passes++;
`else
    checks++; if (s_ret !== c0) $display("FAIL addi_retired: got %0d required %0d", s_ret, c0); else passes++;
`endif
    drain();
  endtask

  task automatic test_sub();
    tb_rf[12] = 32'd2; exp_rf[12] = 32'd2;
    tb_rf[14] = 32'd6; exp_rf[14] = 32'd6;
    instr_valid = 1'b1;
    instr_in = 32'h40E608B3;
    step();
    instr_valid = 1'b0;
    step();
    step();
    checks++; if (s_wen !== 1'b1 || s_alu !== 6'b001000 || s_bsel !== 1'b0) $display("FAIL sub_ctrl: wEn=%b alu=%b bsel=%b required 1/001000/0", s_wen, s_alu, s_bsel); else passes++;
    step();
    checks++; if (tb_rf[17] !== 32'hFFFFFFFC) $display("FAIL sub_x17: got %h required fffffffc", tb_rf[17]); else passes++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] list [4];
    int          k;
    int          wcyc[$];
    int          wrd[$];
    logic        saw_low;
    logic        acc;
    for (int i = 0; i < 4; i++) list[i] = mk_i(12'(i + 5), 5'd0, 3'd0, 5'(i + 5));
    k = 0;
    saw_low = 1'b0;
    for (int n = 0; n < 40 && (k < 4 || exp_busy()); n++) begin
      instr_valid = (k < 4);
      if (k < 4) instr_in = list[k];
      acc = instr_valid && s_ready;
      step();
      if (acc) k++;
      if (!s_ready) saw_low = 1'b1;
      checks++; if (s_ready !== exp_ready()) $display("FAIL b2b_ready: cyc %0d got %b required %b", cyc, s_ready, exp_ready()); else passes++;
      if (s_wen) begin wcyc.push_back(int'(cyc)); wrd.push_back(int'(s_instr[11:7])); end
    end
    instr_valid = 1'b0;
    checks++; if (k != 4) $display("FAIL b2b_accepts: got %0d required 4", k); else passes++;
    checks++; if (!saw_low) $display("FAIL b2b_backpressure: instr_ready never fell, required a low cycle"); else passes++;
    checks++; if (wrd.size() != 4) $display("FAIL b2b_writes: got %0d required 4", wrd.size()); else passes++;
    for (int i = 0; i < wrd.size() && i < 4; i++) begin
      checks++; if (wrd[i] != i + 5) $display("FAIL b2b_order: slot %0d rd=%0d required %0d", i, wrd[i], i + 5); else passes++;
      if (i > 0) begin
        checks++; if (wcyc[i] - wcyc[i-1] != 3) $display("FAIL b2b_spacing: slot %0d gap %0d required 3", i, wcyc[i] - wcyc[i-1]); else passes++;
      end
    end
    step();
    for (int i = 5; i < 9; i++) begin
      checks++; if (tb_rf[i] !== 32'(i)) $display("FAIL b2b_rf: x%0d=%h required %h", i, tb_rf[i], i); else passes++;
    end
    drain();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    int          pulses;
    int          writes;
    logic [15:0] c0;
    bad[0] = 32'h0000007F;
    bad[1] = mk_r(7'h20, 5'd2, 5'd1, 3'd4, 5'd3);
    for (int j = 0; j < 2; j++) begin
      c0 = exp_ret();
      pulses = 0;
      writes = 0;
      instr_valid = 1'b1;
      instr_in = bad[j];
      step();
      instr_valid = 1'b0;
      for (int n = 0; n < 6; n++) begin
        step();
        if (s_ill) pulses++;
        if (s_wen) writes++;
      end
      checks++; if (pulses != 1) $display("FAIL illegal_pulse: instr %h pulses %0d required 1", bad[j], pulses); else passes++;
      checks++; if (writes != 0) $display("FAIL illegal_wen: instr %h writes %0d required 0", bad[j], writes); else passes++;
      checks++; if (s_ret !== c0) $display("FAIL illegal_retired: got %0d required %0d", s_ret, c0); else passes++;
    end
  endtask

  task automatic test_x0();
    int          writes;
    logic [15:0] c0;
    c0 = exp_ret();
    writes = 0;
    instr_valid = 1'b1;
    instr_in = mk_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0);
    step();
    instr_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (s_wen) writes++;
    end
    checks++; if (writes != 0) $display("FAIL x0_wen: writes %0d required 0", writes); else passes++;
`ifdef SEQ_RETIRE_CNT_EN
    checks++; if (s_ret !== c0 + 16'd1) $display("FAIL x0_retired: got %0d required %0d", s_ret, c0 + 16'd1); else passes++;
`else
    checks++; if (s_ret !== c0) $display("FAIL x0_retired: got %0d required %0d", s_ret, c0); else passes++;
`endif
  endtask

  task automatic test_random();
    for (int i = 1; i < 32; i++) begin
      tb_rf[i] = $urandom;
      exp_rf[i] = tb_rf[i];
    end
    for (int n = 0; n < 200; n++) begin
      instr_valid = ($urandom_range(0, 2) != 0);
      instr_in = rand_instr();
      step();
      checks++;
      if (s_wen !== exp_wen() || s_ill !== exp_ill() || s_busy !== exp_busy() || s_ready !== exp_ready())
        $display("FAIL rand_flags: cyc %0d wEn=%b ill=%b busy=%b rdy=%b required %b %b %b %b",
                 cyc, s_wen, s_ill, s_busy, s_ready, exp_wen(), exp_ill(), exp_busy(), exp_ready());
      else passes++;
      checks++; if (s_instr !== m_ir) $display("FAIL rand_instr: cyc %0d got %h required %h", cyc, s_instr, m_ir); else passes++;
      if (exp_wen()) begin
        checks++;
        if (s_alu !== ref_alu(m_ir) || s_bsel !== (m_ir[6:0] == OPI))
          $display("FAIL rand_ctrl: instr %h alu=%b bsel=%b required %b %b", m_ir, s_alu, s_bsel, ref_alu(m_ir), m_ir[6:0] == OPI);
        else passes++;
      end
    end
    drain();
    for (int i = 1; i < 32; i++) begin
      checks++; if (tb_rf[i] !== exp_rf[i]) $display("FAIL rand_rf: x%0d=%h required %h", i, tb_rf[i], exp_rf[i]); else passes++;
    end
    checks++; if (s_ret !== exp_ret()) $display("FAIL rand_retired: got %0d required %0d", s_ret, exp_ret()); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] x20;
    int          writes;
    instr_valid = 1'b1;
    instr_in = mk_i(12'h123, 5'd0, 3'd0, 5'd20);
    step();
    instr_in = mk_i(12'h045, 5'd0, 3'd0, 5'd21);
    step();
    instr_in = mk_i(12'h067, 5'd0, 3'd0, 5'd22);
    step();
    instr_valid = 1'b0;
    checks++; if (s_wen !== 1'b1 || s_busy !== 1'b1) $display("FAIL rmid_exec: wEn=%b busy=%b required 1/1", s_wen, s_busy); else passes++;
    x20 = tb_rf[20];
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    sample();
    checks++;
    if (s_wen !== 1'b0 || s_instr !== 32'd0 || s_alu !== 6'd0 || s_bsel !== 1'b0 || s_ill !== 1'b0 ||
        s_busy !== 1'b0 || s_ready !== 1'b0 || s_ret !== 16'd0)
      $display("FAIL rmid_outputs: wEn=%b instr=%h alu=%b bsel=%b ill=%b busy=%b rdy=%b cnt=%0d required all 0",
               s_wen, s_instr, s_alu, s_bsel, s_ill, s_busy, s_ready, s_ret);
    else passes++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    writes = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (s_wen) writes++;
    end
    checks++; if (s_busy !== 1'b0 || s_ready !== 1'b1) $display("FAIL rmid_after: busy=%b rdy=%b required 0/1", s_busy, s_ready); else passes++;
    checks++; if (writes != 0) $display("FAIL rmid_writes: %0d required 0", writes); else passes++;
    checks++; if (tb_rf[20] !== x20) $display("FAIL rmid_x20: got %h required %h", tb_rf[20], x20); else passes++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_x0();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
